// File: rtl/spi_frame_tx_if.sv
// Parallel request/status bus and SPI wire bundle of the frame transmitter.
// The host side (master) issues start with the three frame bytes and watches
// busy/done; the transmitter (slave) drives the SPI wires cs/sck/sdo.
interface spi_frame_tx_if;
    logic       start;
    logic [7:0] command;
    logic [7:0] databyte1;
    logic [7:0] databyte2;
    logic       busy;
    logic       done;
    logic       cs;
    logic       sck;
    logic       sdo;

    modport master (
        output start, command, databyte1, databyte2,
        input  busy, done, cs, sck, sdo
    );

    modport slave (
        input  start, command, databyte1, databyte2,
        output busy, done, cs, sck, sdo
    );
endinterface

// File: rtl/spi_frame_tx.sv
// SPI frame transmitter: sends a 3-byte frame (command, databyte1, databyte2)
// as 24 bits MSB-first. cs is active-high for the whole frame, sck idles low,
// sdo only moves while sck is low so the receiver can sample on sck rise.
// Every output comes straight from a register.
module spi_frame_tx #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_frame_tx_if.slave     bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [4:0]       LAST_BIT = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  divCnt_q;
    logic [DIV_W-1:0]  divCnt_d;
    logic [GAP_W-1:0]  gapCnt_q;
    logic [GAP_W-1:0]  gapCnt_d;
    logic [4:0]        bitCnt_q;
    logic [23:0]       shreg_q;
    logic              busy_q;
    logic              done_q;
    logic              cs_q;
    logic              sck_q;
    logic              divExpired;
    logic              gapExpired;

    assign divExpired = (divCnt_q == DIV_LAST);
    assign gapExpired = (gapCnt_q == GAP_LAST);

    // Free-running wrap of the half-period and gap counters; the FSM decides
    // when they are allowed to advance.
    always_comb begin
        divCnt_d = divExpired ? '0 : divCnt_q + DIV_W'(1);
        gapCnt_d = gapExpired ? '0 : gapCnt_q + GAP_W'(1);
    end

    // Frame sequencer: every state change happens on a counter expiry, so the
    // half-period counter is always back at zero when a new phase starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            divCnt_q <= '0;
            gapCnt_q <= '0;
            bitCnt_q <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b0;
            sck_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q   <= 1'b0;
                    cs_q     <= 1'b0;
                    sck_q    <= 1'b0;
                    divCnt_q <= '0;
                    gapCnt_q <= '0;
                    bitCnt_q <= '0;
                    if (bus.start) begin
                        shreg_q <= {bus.command, bus.databyte1, bus.databyte2};
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP, SHIFT_LO: begin
                    divCnt_q <= divCnt_d;
                    if (divExpired) begin
                        sck_q   <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    divCnt_q <= divCnt_d;
                    if (divExpired) begin
                        sck_q <= 1'b0;
                        if (bitCnt_q == LAST_BIT) begin
                            state_q <= HOLD;
                        end else begin
                            shreg_q  <= {shreg_q[22:0], 1'b0};
                            bitCnt_q <= bitCnt_q + 5'd1;
                            state_q  <= SHIFT_LO;
                        end
                    end
                end
                HOLD: begin
                    divCnt_q <= divCnt_d;
                    if (divExpired) begin
                        cs_q     <= 1'b0;
                        shreg_q  <= '0;
                        gapCnt_q <= '0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    gapCnt_q <= gapCnt_d;
                    if (gapExpired) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.cs   = cs_q;
    assign bus.sck  = sck_q;
    assign bus.sdo  = shreg_q[23];

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (CLK_DIV=4/CS_GAP=2 and
// CLK_DIV=1/CS_GAP=1) driven by directed and random frames. A wire-level
// receiver model samples sdo on sck rise and measures frame timing; captured
// frames are compared with a queue of the frames the bench asked to send.
module tb_spi_frame_tx;

    localparam int DIV0 = 4;
    localparam int GAP0 = 2;
    localparam int DIV1 = 1;
    localparam int GAP1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Free-running system clock shared by both instances.
    always #5 clk = ~clk;

    spi_frame_tx_if bus0 ();
    spi_frame_tx_if bus1 ();

    spi_frame_tx #(.CLK_DIV(DIV0), .CS_GAP(GAP0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    spi_frame_tx #(.CLK_DIV(DIV1), .CS_GAP(GAP1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    logic [1:0] csW, sckW, sdoW, busyW, doneW;
    assign csW   = {bus1.cs,   bus0.cs};
    assign sckW  = {bus1.sck,  bus0.sck};
    assign sdoW  = {bus1.sdo,  bus0.sdo};
    assign busyW = {bus1.busy, bus0.busy};
    assign doneW = {bus1.done, bus0.done};

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [23:0] expQ[$];

    logic [1:0]  prevCs   = 2'b00;
    logic [1:0]  prevSck  = 2'b00;
    logic [1:0]  prevSdo  = 2'b00;
    logic [1:0]  prevDone = 2'b00;
    logic [23:0] bitBuf[2]    = '{24'h0, 24'h0};
    logic [23:0] lastFrame[2] = '{24'h0, 24'h0};
    int highLen[2]       = '{0, 0};
    int lowLen[2]        = '{0, 0};
    int rises[2]         = '{0, 0};
    int runLen[2]        = '{0, 0};
    int framePhaseErr[2] = '{0, 0};
    int busyLen[2]       = '{0, 0};
    int lastRises[2]     = '{0, 0};
    int lastHigh[2]      = '{0, 0};
    int lastGap[2]       = '{0, 0};
    int lastBusy[2]      = '{0, 0};
    int frameCount[2]    = '{0, 0};
    int partialCount[2]  = '{0, 0};
    int doneCount[2]     = '{0, 0};
    int doneLong[2]      = '{0, 0};
    int edgeViol[2]      = '{0, 0};
    int phaseErrTotal[2] = '{0, 0};

    function automatic int divOf(input int k);
        return (k == 0) ? DIV0 : DIV1;
    endfunction

    function automatic int gapOf(input int k);
        return (k == 0) ? GAP0 : GAP1;
    endfunction

    function automatic logic [7:0] rndByte();
        return 8'($urandom);
    endfunction

    // Receiver model: shifts in sdo on every sck rise while cs is high, and
    // measures cs-high/low lengths, sck phase lengths, busy length and done
    // pulses. It also flags sdo moving while sck is high and sck high outside cs.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                if (prevCs[k]) partialCount[k]++;
                highLen[k] = 0;
                lowLen[k]  = 0;
                busyLen[k] = 0;
                runLen[k]  = 0;
                rises[k]   = 0;
            end else begin
                if (csW[k]) begin
                    if (!prevCs[k]) begin
                        if (frameCount[k] > 0) lastGap[k] = lowLen[k];
                        highLen[k] = 0;
                        rises[k] = 0;
                        bitBuf[k] = 24'h0;
                        runLen[k] = 0;
                        framePhaseErr[k] = 0;
                    end else if ((sdoW[k] !== prevSdo[k]) && sckW[k]) begin
                        edgeViol[k]++;
                    end
                    if (prevCs[k] && (sckW[k] !== prevSck[k])) begin
                        if (runLen[k] != divOf(k)) framePhaseErr[k]++;
                        runLen[k] = 0;
                    end
                    runLen[k]++;
                    highLen[k]++;
                    if (sckW[k] && !prevSck[k]) begin
                        bitBuf[k] = {bitBuf[k][22:0], sdoW[k]};
                        rises[k]++;
                    end
                end else begin
                    if (sckW[k] !== 1'b0) edgeViol[k]++;
                    if (prevCs[k]) begin
                        if (runLen[k] != divOf(k)) framePhaseErr[k]++;
                        lastFrame[k] = bitBuf[k];
                        lastRises[k] = rises[k];
                        lastHigh[k]  = highLen[k];
                        phaseErrTotal[k] += framePhaseErr[k];
                        frameCount[k]++;
                        lowLen[k] = 0;
                    end
                    lowLen[k]++;
                end
                if (doneW[k]) begin
                    lastBusy[k] = busyLen[k];
                    busyLen[k] = 0;
                    doneCount[k]++;
                    if (prevDone[k]) doneLong[k]++;
                end else if (busyW[k]) begin
                    busyLen[k]++;
                end else begin
                    busyLen[k] = 0;
                end
            end
            prevCs[k]   = csW[k];
            prevSck[k]  = sckW[k];
            prevSdo[k]  = sdoW[k];
            prevDone[k] = doneW[k];
        end
    end

    // Hard stop in case a wait loop is ever left unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] c, input logic [7:0] d1,
                                 input logic [7:0] d2, input bit accept);
        if (k == 0) begin
            bus0.command = c; bus0.databyte1 = d1; bus0.databyte2 = d2; bus0.start = 1'b1;
        end else begin
            bus1.command = c; bus1.databyte1 = d1; bus1.databyte2 = d2; bus1.start = 1'b1;
        end
        if (accept) expQ.push_back({c, d1, d2});
        tick();
        if (k == 0) bus0.start = 1'b0;
        else        bus1.start = 1'b0;
    endtask

    task automatic scribble(input int k);
        if (k == 0) begin
            bus0.command = rndByte(); bus0.databyte1 = rndByte(); bus0.databyte2 = rndByte();
        end else begin
            bus1.command = rndByte(); bus1.databyte1 = rndByte(); bus1.databyte2 = rndByte();
        end
    endtask

    task automatic waitDone(input int k, input int budget);
        int n = 0;
        while (!doneW[k] && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(doneW[k]), 32'd1);
    endtask

    task automatic waitRises(input int k, input int target, input int budget);
        int n = 0;
        while (rises[k] < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("rises_reached", 32'(rises[k] >= target), 32'd1);
    endtask

    task automatic checkFrame(input int k, input string tag);
        logic [23:0] exp;
        waitDone(k, 49 * divOf(k) + gapOf(k) + 20);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 24'hx;
        checkOutput({tag, "_frame"},  32'(lastFrame[k]), 32'(exp));
        checkOutput({tag, "_rises"},  32'(lastRises[k]), 32'd24);
        checkOutput({tag, "_cshigh"}, 32'(lastHigh[k]),  32'(49 * divOf(k)));
        checkOutput({tag, "_busy"},   32'(lastBusy[k]),  32'(49 * divOf(k) + gapOf(k)));
    endtask

    task automatic checkIdleOutputs(input int k, input string tag);
        checkOutput({tag, "_cs"},   32'(csW[k]),   32'd0);
        checkOutput({tag, "_sck"},  32'(sckW[k]),  32'd0);
        checkOutput({tag, "_sdo"},  32'(sdoW[k]),  32'd0);
        checkOutput({tag, "_busy"}, 32'(busyW[k]), 32'd0);
        checkOutput({tag, "_done"}, 32'(doneW[k]), 32'd0);
    endtask

    // Directed sequence followed by randomized frames on both instances.
    initial begin
        int  d;
        int  p;
        bit  b2b;

        bus0.start = 1'b0; bus0.command = '0; bus0.databyte1 = '0; bus0.databyte2 = '0;
        bus1.start = 1'b0; bus1.command = '0; bus1.databyte1 = '0; bus1.databyte2 = '0;
        reset = 1'b1;
        repeat (3) tick();
        checkIdleOutputs(0, "rst0");
        checkIdleOutputs(1, "rst1");
        reset = 1'b0;
        repeat (2) tick();

        $display("[TB] single frame with an ignored start mid-frame");
        applyStimulus(0, 8'hA5, 8'h3C, 8'hF0, 1'b1);
        repeat (9) tick();
        applyStimulus(0, 8'h11, 8'h22, 8'h33, 1'b0);
        d = doneCount[0];
        checkFrame(0, "dir");
        repeat (6) tick();
        checkOutput("one_done", 32'(doneCount[0] - d), 32'd1);
        checkOutput("idle_busy", 32'(busyW[0]), 32'd0);
        checkOutput("dir_edges", 32'(edgeViol[0]), 32'd0);

        $display("[TB] back-to-back frames");
        applyStimulus(0, rndByte(), rndByte(), rndByte(), 1'b1);
        checkFrame(0, "b2b_a");
        applyStimulus(0, 8'h01, 8'h02, 8'h03, 1'b1);
        checkOutput("b2b_gap", 32'(lastGap[0]), 32'(GAP0 + 1));
        checkFrame(0, "b2b_b");

        $display("[TB] random frames, CLK_DIV=4");
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            applyStimulus(0, rndByte(), rndByte(), rndByte(), 1'b1);
            scribble(0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 60)) tick();
                applyStimulus(0, rndByte(), rndByte(), rndByte(), 1'b0);
            end
            checkFrame(0, "rnd4");
        end

        $display("[TB] reset in the middle of a frame");
        repeat (2) tick();
        applyStimulus(0, rndByte(), rndByte(), rndByte(), 1'b0);
        waitRises(0, 10, 200);
        p = partialCount[0];
        d = doneCount[0];
        reset = 1'b1;
        tick();
        checkIdleOutputs(0, "abort");
        reset = 1'b0;
        repeat (GAP0 + 6) tick();
        checkOutput("abort_partial", 32'(partialCount[0] - p), 32'd1);
        checkOutput("abort_nodone", 32'(doneCount[0] - d), 32'd0);
        applyStimulus(0, 8'hFF, 8'h00, 8'h81, 1'b1);
        checkFrame(0, "post_rst");

        $display("[TB] reset together with start");
        repeat (2) tick();
        reset = 1'b1;
        applyStimulus(0, rndByte(), rndByte(), rndByte(), 1'b0);
        checkOutput("rst_start_cs", 32'(csW[0]), 32'd0);
        checkOutput("rst_start_busy", 32'(busyW[0]), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("rst_start_cs2", 32'(csW[0]), 32'd0);

        $display("[TB] CLK_DIV=1 instance");
        applyStimulus(1, 8'h80, 8'h00, 8'h01, 1'b1);
        checkFrame(1, "div1");
        b2b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, rndByte(), rndByte(), rndByte(), 1'b1);
            scribble(1);
            if (b2b) checkOutput("div1_gap", 32'(lastGap[1]), 32'(GAP1 + 1));
            checkFrame(1, "rnd1");
            b2b = ($urandom_range(0, 1) == 1);
            if (!b2b) repeat ($urandom_range(1, 3)) tick();
        end

        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            checkOutput("edge_viol", 32'(edgeViol[k]), 32'd0);
            checkOutput("phase_len", 32'(phaseErrTotal[k]), 32'd0);
            checkOutput("done_width", 32'(doneLong[k]), 32'd0);
        end
        checkOutput("exp_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- SPI frame transmitter: the transmitting end of the 3-byte command link (command, databyte1, databyte2) that the graphics card's SPI receiver consumes.
- Used as the host-side driver on a companion FPGA and as the stimulus source in loopback benches for the receiver/decoder path.
- Accepts a parallel frame on a start strobe, then serializes 24 bits MSB-first on cs/sck/sdo.

Parameters:
- CLK_DIV, 4, sck half-period in clk cycles; legal range ≥1.
- CS_GAP, 2, minimum clk cycles cs stays low after a frame before the next frame may begin; legal range ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send a frame; honoured only in IDLE.
- command  input  8  first byte on the wire.
- databyte1  input  8  second byte.
- databyte2  input  8  third byte.
- busy  output  1  high while a frame is being sent, including the CS_GAP interval.
- done  output  1  one-cycle pulse when the transmitter returns to IDLE after a frame.
- cs  output  1  frame enable, active-high, high for the whole frame.
- sck  output  1  serial clock, idles low.
- sdo  output  1  serial data, MSB-first.

Behaviour:
- Reset (synchronous, active-high): on the first rising clk edge with reset=1, cs=0, sck=0, sdo=0, busy=0, done=0, state=IDLE, all counters=0. Reset mid-frame aborts the frame; no done pulse.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Shift register: 24 bits. On accept it loads {command, databyte1, databyte2}. sdo always drives shreg[23].
- Half-period counter: counts 0..CLK_DIV-1. Bit counter: 5 bits, counts 0..23.
- Wire protocol: sdo changes only while sck is low (at sck falling edges or in SETUP). The receiver samples on sck rising edges. sck pulses only while cs=1.
- IDLE:
  - busy=0, cs=0, sck=0.
  - start=1 → latch the frame, set cs=1, busy=1, sdo=command[7], go to SETUP.
  - start=0 → stay in IDLE.
- SETUP:
  - cs=1, sck=0 for CLK_DIV cycles, then raise sck and go to SHIFT_HI.
- SHIFT_HI:
  - sck=1 for CLK_DIV cycles.
  - At expiry with bit counter < 23: drive sck=0, shift shreg left by 1 (sdo = next bit), increment the bit counter, go to SHIFT_LO.
  - At expiry with bit counter = 23: drive sck=0, go to HOLD.
- SHIFT_LO:
  - sck=0 for CLK_DIV cycles, then raise sck and go to SHIFT_HI.
- HOLD:
  - sck=0, cs=1 for CLK_DIV cycles, then drive cs=0 and sdo=0, go to GAP.
- GAP:
  - cs=0 for CS_GAP cycles, then go to IDLE with busy=0 and done=1 for exactly that first IDLE cycle.
- Timing:
  - cs high duration = CLK_DIV + 48·CLK_DIV = 49·CLK_DIV cycles.
  - Each sck high and low phase lasts exactly CLK_DIV cycles.
  - Exactly 24 sck rising edges per frame.
- Handshake:
  - start while busy=1 is ignored and not queued.
  - Input bytes are sampled only on the accept cycle; later changes do not affect the frame in flight.
  - start in the same cycle done=1 is accepted, so back-to-back frames are separated by exactly CS_GAP cs-low cycles plus the 1 IDLE cycle.
- Simultaneous reset and start: reset wins; no frame starts.
- CLK_DIV=1: sck toggles every clk cycle; cs high for 49 cycles; same state sequence.

Test Plan:
- Single frame 0xA5,0x3C,0xF0 with CLK_DIV=4 into a bench SPI receiver model sampling on sck rise → receiver captures command=0xA5, databyte1=0x3C, databyte2=0xF0. Also: 24 sck rises, cs high for 196 cycles, one done pulse, busy high until the done cycle.
- Timing check (same frame): sdo stable throughout every sck-high phase; every sdo transition occurs while sck=0; sck=0 whenever cs=0.
- start pulsed again 10 cycles into the frame with different bytes 0x11,0x22,0x33 → ignored. Wire still carries 0xA5,0x3C,0xF0; exactly one done pulse.
- Back-to-back: second start (0x01,0x02,0x03) asserted in the done cycle of the first frame → second frame begins. cs low for exactly CS_GAP+1=3 cycles between frames; receiver captures both frames in order.
- reset asserted at bit 10 of a frame → next cycle cs=0, sck=0, sdo=0, busy=0, no done. A following start of 0xFF,0x00,0x81 sends cleanly and is captured intact.
- CLK_DIV=1, CS_GAP=1, frame 0x80,0x00,0x01 → cs high 49 cycles, sck period 2 cycles, receiver captures 0x80,0x00,0x01.
